// File: rtl/button_debounce_repeat_pkg.sv
// Shared constants for the front-panel button front-end: button indices,
// channel FSM encoding and default timing at 50 MHz.
package button_debounce_repeat_pkg;

   localparam int BTN_PREV    = 0;
   localparam int BTN_NEXT    = 1;
   localparam int BTN_OKAY    = 2;
   localparam int BTN_CANCEL  = 3;
   localparam int NUM_BUTTONS = BTN_CANCEL + 1;

   localparam int DEF_DEBOUNCE_CYCLES     = 500000;
   localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
   localparam int DEF_REPEAT_RATE_CYCLES  = 5000000;
   localparam logic [NUM_BUTTONS-1:0] DEF_REPEAT_MASK =
      NUM_BUTTONS'((1 << BTN_PREV) | (1 << BTN_NEXT));
   localparam logic DEF_PRESSED_LEVEL = 1'b0;

   typedef enum logic [1:0] {
      RELEASED  = 2'd0,
      HELD      = 2'd1,
      REPEATING = 2'd2
   } chan_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_debounce_repeat_channel.sv
// One button: 2-FF synchroniser, debounce counter, press/repeat FSM and
// repeat counter; emits a registered single-cycle pulse per press/repeat.
module button_channel
   import button_debounce_repeat_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
   parameter int   REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
   parameter int   REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
   parameter logic REPEAT_EN           = 1'b0,
   parameter logic PRESSED_LEVEL       = DEF_PRESSED_LEVEL
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic raw,
   output logic pulse,
   output logic level
);

   localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);
   localparam int REP_W = cnt_width(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_CYCLES - 1);

   logic sync1, sync2, pressed_s;
   logic [DB_W-1:0] db_cnt;
   logic differs, db_done, rise_evt, fall_evt;
   chan_state_e state, state_nxt;
   logic [REP_W-1:0] rep_cnt;
   logic pulse_nxt;

   // Synchroniser is not gated by en so a held button is already settled
   // when the channel is re-enabled.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= ~PRESSED_LEVEL;
         sync2 <= ~PRESSED_LEVEL;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   assign pressed_s = (sync2 == PRESSED_LEVEL);
   assign differs   = (pressed_s != level);
   assign db_done   = differs && (db_cnt == DB_LAST);
   assign rise_evt  = db_done && pressed_s;
   assign fall_evt  = db_done && !pressed_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt <= '0;
         level  <= 1'b0;
      end else if (!en) begin
         db_cnt <= '0;
         level  <= 1'b0;
      end else if (!differs) begin
         db_cnt <= '0;
      end else if (db_done) begin
         db_cnt <= '0;
         level  <= pressed_s;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state <= RELEASED;
      else if (!en) state <= RELEASED;
      else          state <= state_nxt;
   end

   // NOTE: every combinational output gets a default before the case so no
   // path through the block can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         RELEASED:  if (rise_evt) state_nxt = HELD;
         HELD: begin
            if (fall_evt)                              state_nxt = RELEASED;
            else if (REPEAT_EN && rep_cnt == DELAY_LAST) state_nxt = REPEATING;
         end
         REPEATING: if (fall_evt) state_nxt = RELEASED;
         default:   state_nxt = RELEASED;
      endcase
   end

   // A debounced release wins over a coincident repeat tick: release never pulses.
   always_comb begin
      pulse_nxt = 1'b0;
      case (state)
         RELEASED:  pulse_nxt = rise_evt;
         HELD:      pulse_nxt = REPEAT_EN && !fall_evt && (rep_cnt == DELAY_LAST);
         REPEATING: pulse_nxt = !fall_evt && (rep_cnt == RATE_LAST);
         default:   pulse_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt <= '0;
         pulse   <= 1'b0;
      end else if (!en) begin
         rep_cnt <= '0;
         pulse   <= 1'b0;
      end else begin
         pulse <= pulse_nxt;
         if (pulse_nxt || state_nxt != state)
            rep_cnt <= '0;
         else if ((state == HELD && REPEAT_EN) || state == REPEATING)
            rep_cnt <= rep_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/button_debounce_repeat.sv
// TFT43 front-panel button front-end: four independent debounce/repeat
// channels feeding the cursor/period-select adapter.
module button_debounce_repeat
   import button_debounce_repeat_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES                = DEF_DEBOUNCE_CYCLES,
   parameter int   REPEAT_DELAY_CYCLES            = DEF_REPEAT_DELAY_CYCLES,
   parameter int   REPEAT_RATE_CYCLES             = DEF_REPEAT_RATE_CYCLES,
   parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK  = DEF_REPEAT_MASK,
   parameter logic PRESSED_LEVEL                  = DEF_PRESSED_LEVEL
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] iButton,
   output logic [3:0] oButton,
   output logic [3:0] oLevel
);

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
      button_channel #(
         .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
         .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
         .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
         .REPEAT_EN          (REPEAT_MASK[i]),
         .PRESSED_LEVEL      (PRESSED_LEVEL)
      ) u_chan (
         .clk  (clk),
         .rst_n(rst_n),
         .en   (en),
         .raw  (iButton[i]),
         .pulse(oButton[i]),
         .level(oLevel[i])
      );
   end

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Bench for button_debounce_repeat: directed timing scenarios plus a random
// run against a run-length/arithmetic reference model.
module tb_button_debounce_repeat;
   import button_debounce_repeat_pkg::*;

   localparam int DB   = 4;
   localparam int DLY  = 20;
   localparam int RATE = 8;
   localparam logic [3:0] MASK = 4'b0011;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [3:0] iButton = 4'hF;
   logic [3:0] oButton, oLevel;

   int tests = 0;
   int fails = 0;

   logic [3:0] btn_log[$];
   logic [3:0] lvl_log[$];
   int         pulses[$];

   // Reference model state
   logic [3:0] m_p1, m_p2, m_level, m_pulse;
   int         m_run[4];
   int         m_press_t[4];
   int         m_t;

   button_debounce_repeat #(
      .DEBOUNCE_CYCLES    (DB),
      .REPEAT_DELAY_CYCLES(DLY),
      .REPEAT_RATE_CYCLES (RATE),
      .REPEAT_MASK        (MASK),
      .PRESSED_LEVEL      (1'b0)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .iButton(iButton),
      .oButton(oButton),
      .oLevel (oLevel)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_log();
      btn_log.delete();
      lvl_log.delete();
      btn_log.push_back(oButton);
      lvl_log.push_back(oLevel);
   endtask

   task automatic run(input int n);
      repeat (n) begin
         tick();
         btn_log.push_back(oButton);
         lvl_log.push_back(oLevel);
      end
   endtask

   task automatic idle();
      iButton = 4'hF;
      en      = 1'b1;
      repeat (12) tick();
   endtask

   function automatic void collect_pulses(input int b);
      pulses.delete();
      foreach (btn_log[k]) if (btn_log[k][b]) pulses.push_back(k);
   endfunction

   function automatic bit same_list(input int exp[$]);
      if (exp.size() != pulses.size()) return 1'b0;
      foreach (exp[k]) if (exp[k] != pulses[k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic string list_str(input int q[$]);
      string s = "{";
      foreach (q[k]) s = {s, $sformatf(k == 0 ? "%0d" : ",%0d", q[k])};
      return {s, "}"};
   endfunction

   // Model: level flips after DB consecutive disagreeing synchronised
   // samples; repeats fall at press+DLY+n*RATE while the level stays high.
   task automatic model_reset();
      m_p1 = '0; m_p2 = '0; m_level = '0; m_pulse = '0; m_t = 0;
      for (int b = 0; b < 4; b++) begin
         m_run[b] = 0;
         m_press_t[b] = 0;
      end
   endtask

   task automatic model_edge(input logic [3:0] raw, input logic en_i);
      m_t++;
      for (int b = 0; b < 4; b++) begin
         bit flipped;
         int d;
         flipped    = 1'b0;
         m_pulse[b] = 1'b0;
         if (!en_i) begin
            m_level[b] = 1'b0;
            m_run[b]   = 0;
         end else begin
            if (m_p2[b] != m_level[b]) m_run[b]++;
            else                       m_run[b] = 0;
            if (m_run[b] == DB) begin
               m_level[b] = m_p2[b];
               m_run[b]   = 0;
               flipped    = 1'b1;
               if (m_level[b]) begin
                  m_pulse[b]   = 1'b1;
                  m_press_t[b] = m_t;
               end
            end
            if (!flipped && m_level[b] && MASK[b]) begin
               d = m_t - m_press_t[b];
               if (d >= DLY && (d - DLY) % RATE == 0) m_pulse[b] = 1'b1;
            end
         end
      end
      m_p2 = m_p1;
      m_p1 = ~raw;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; iButton = 4'hF;
      repeat (3) tick();
      tests++;
      if (oButton !== 4'h0) begin
         fails++; $display("FAIL reset_button: got %b expected 0000", oButton);
      end
      tests++;
      if (oLevel !== 4'h0) begin
         fails++; $display("FAIL reset_level: got %b expected 0000", oLevel);
      end
      iButton = 4'h0;
      repeat (10) tick();
      tests++;
      if (oButton !== 4'h0 || oLevel !== 4'h0) begin
         fails++; $display("FAIL reset_hold_pressed: got btn %b lvl %b expected 0000/0000", oButton, oLevel);
      end
      iButton = 4'hF;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (8) tick();
      tests++;
      if (oButton !== 4'h0 || oLevel !== 4'h0) begin
         fails++; $display("FAIL reset_release_idle: got btn %b lvl %b expected 0000/0000", oButton, oLevel);
      end
   endtask

   task automatic test_clean_press();
      int exp[$] = '{6};
      start_log();
      iButton[1] = 1'b0;
      run(15);
      iButton[1] = 1'b1;
      run(15);
      collect_pulses(1);
      tests++;
      if (!same_list(exp)) begin
         fails++; $display("FAIL clean_press_pulses: got %s expected %s", list_str(pulses), list_str(exp));
      end
      tests++;
      if (lvl_log[5][1] !== 1'b0 || lvl_log[6][1] !== 1'b1) begin
         fails++; $display("FAIL clean_press_level_rise: got %b%b expected 01", lvl_log[5][1], lvl_log[6][1]);
      end
      tests++;
      if (lvl_log[20][1] !== 1'b1 || lvl_log[21][1] !== 1'b0) begin
         fails++; $display("FAIL clean_press_level_fall: got %b%b expected 10", lvl_log[20][1], lvl_log[21][1]);
      end
      idle();
   endtask

   task automatic test_bounce();
      int exp[$] = '{18};
      start_log();
      for (int k = 0; k < 6; k++) begin
         iButton[0] = k[0];
         run(2);
      end
      iButton[0] = 1'b0;
      run(25);
      collect_pulses(0);
      tests++;
      if (!same_list(exp)) begin
         fails++; $display("FAIL bounce_pulses: got %s expected %s", list_str(pulses), list_str(exp));
      end
      idle();
   endtask

   task automatic test_auto_repeat();
      int exp[$] = '{6, 26, 34, 42, 50, 58};
      start_log();
      iButton[0] = 1'b0;
      run(56);
      iButton[0] = 1'b1;
      run(20);
      collect_pulses(0);
      tests++;
      if (!same_list(exp)) begin
         fails++; $display("FAIL auto_repeat_pulses: got %s expected %s", list_str(pulses), list_str(exp));
      end
      tests++;
      if (lvl_log[61][0] !== 1'b1 || lvl_log[62][0] !== 1'b0) begin
         fails++; $display("FAIL auto_repeat_level_fall: got %b%b expected 10", lvl_log[61][0], lvl_log[62][0]);
      end
      idle();
   endtask

   task automatic test_no_repeat_okay();
      int exp[$] = '{6};
      start_log();
      iButton[2] = 1'b0;
      run(100);
      iButton[2] = 1'b1;
      run(15);
      collect_pulses(2);
      tests++;
      if (!same_list(exp)) begin
         fails++; $display("FAIL okay_no_repeat_pulses: got %s expected %s", list_str(pulses), list_str(exp));
      end
      idle();
   endtask

   task automatic test_simultaneous();
      start_log();
      iButton = 4'b0110;
      run(10);
      iButton = 4'hF;
      run(10);
      tests++;
      if (btn_log[5] !== 4'b0000 || btn_log[6] !== 4'b1001 || btn_log[7] !== 4'b0000) begin
         fails++; $display("FAIL simultaneous_pulse: got %b,%b,%b expected 0000,1001,0000",
                           btn_log[5], btn_log[6], btn_log[7]);
      end
      tests++;
      if (lvl_log[6] !== 4'b1001) begin
         fails++; $display("FAIL simultaneous_level: got %b expected 1001", lvl_log[6]);
      end
      idle();
   endtask

   task automatic test_enable_drop();
      int exp[$] = '{6, 26, 39, 52};
      start_log();
      iButton[1] = 1'b0;
      run(30);
      en = 1'b0;
      run(5);
      en = 1'b1;
      run(10);
      rst_n = 1'b0;
      #1;
      tests++;
      if (oButton !== 4'h0 || oLevel !== 4'h0) begin
         fails++; $display("FAIL reset_mid_hold_immediate: got btn %b lvl %b expected 0000/0000", oButton, oLevel);
      end
      run(1);
      rst_n = 1'b1;
      run(10);
      tests++;
      if (lvl_log[30][1] !== 1'b1 || lvl_log[31] !== 4'h0 || btn_log[31] !== 4'h0) begin
         fails++; $display("FAIL enable_drop_clear: got lvl %b->%b btn %b expected 1->0000 btn 0000",
                           lvl_log[30][1], lvl_log[31], btn_log[31]);
      end
      collect_pulses(1);
      tests++;
      if (!same_list(exp)) begin
         fails++; $display("FAIL enable_reset_repress_pulses: got %s expected %s", list_str(pulses), list_str(exp));
      end
      idle();
   endtask

   task automatic test_random();
      logic [3:0] ib;
      logic       do_rst;
      ib = 4'hF;
      iButton = ib; en = 1'b1;
      rst_n = 1'b0;
      model_reset();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 24) == 0) ib[b] = ~ib[b];
         iButton = ib;
         en      = ($urandom_range(0, 149) != 0);
         do_rst  = ($urandom_range(0, 399) == 0);
         if (do_rst) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            tests++;
            if (oButton !== 4'h0 || oLevel !== 4'h0) begin
               fails++; $display("FAIL random_async_reset c=%0d: got btn %b lvl %b expected 0000/0000",
                                 c, oButton, oLevel);
            end
         end
         tick();
         if (!do_rst) model_edge(ib, en);
         tests++;
         if (oButton !== m_pulse) begin
            fails++; $display("FAIL random_button c=%0d: got %b expected %b", c, oButton, m_pulse);
         end
         tests++;
         if (oLevel !== m_level) begin
            fails++; $display("FAIL random_level c=%0d: got %b expected %b", c, oLevel, m_level);
         end
         if (do_rst) rst_n = 1'b1;
      end
      en = 1'b1;
      idle();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat();
      test_no_repeat_okay();
      test_simultaneous();
      test_enable_drop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/button_debounce_repeat.md
Name: button_debounce_repeat

Overview:
Front-end for the four TFT43 front-panel push buttons: [0] Previous, [1] Next, [2] Okay, [3] Cancel.
- Synchronises the raw pins, debounces each one and emits a single-cycle press pulse per confirmed press.
- Generates auto-repeat pulses on long press for the navigation buttons.
- Output feeds the cursor/period-select adapter stage directly downstream, which consumes the pulses on oButton.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a level change (10 ms @ 50 MHz); minimum 2.
REPEAT_DELAY_CYCLES, 25000000, cycles from press pulse to first repeat pulse (500 ms).
REPEAT_RATE_CYCLES, 5000000, cycles between subsequent repeat pulses (100 ms).
REPEAT_MASK, 4'b0011, per-button auto-repeat enable (Previous/Next only).
PRESSED_LEVEL, 1'b0, raw pin level meaning "pressed".

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; low clears all channel state
iButton  input  4  raw asynchronous button pins, [0] Prev [1] Next [2] Okay [3] Cancel
oButton  output  4  registered single-cycle press/repeat pulses, active-high
oLevel  output  4  registered debounced pressed level, active-high

Behaviour:
- Reset: clk and rst_n only; rst_n is asynchronous, active-low. While rst_n=0: oButton=0, oLevel=0, synchronisers loaded with ~PRESSED_LEVEL, all counters 0, all channels RELEASED.
- Synchroniser: 2-FF per bit. pressed_s = (sync2 == PRESSED_LEVEL).
- Debounce, per channel, independent:
  - Counter db_cnt, width $clog2(DEBOUNCE_CYCLES).
  - If pressed_s != oLevel: db_cnt increments.
  - If pressed_s == oLevel: db_cnt clears.
  - When db_cnt == DEBOUNCE_CYCLES-1 and pressed_s still differs: oLevel toggles on the next edge and db_cnt clears.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Latency: a clean raw edge sampled at edge E produces the oLevel change and press pulse at edge E+2+DEBOUNCE_CYCLES.
- Channel FSM states:
  - RELEASED: on oLevel rising, oButton[i]=1 for one cycle, rep_cnt cleared, go to HELD.
  - HELD: if REPEAT_MASK[i]=0, stay in HELD until oLevel falls, then go to RELEASED. Otherwise rep_cnt counts; at rep_cnt == REPEAT_DELAY_CYCLES-1, pulse, clear rep_cnt, go to REPEATING.
  - REPEATING: at rep_cnt == REPEAT_RATE_CYCLES-1, pulse and clear rep_cnt. When oLevel falls, go to RELEASED with no pulse.
- Release generates no pulse. The oLevel falling edge has the same debounce latency as the rising edge.
- rep_cnt width: $clog2 of the larger of REPEAT_DELAY_CYCLES and REPEAT_RATE_CYCLES. It never wraps; it is cleared on every pulse and on every state change.
- Simultaneous presses: channels are fully independent. Several oButton bits may be high in the same cycle; priority belongs to the consumer.
- en=0:
  - On the next edge: oButton=0, oLevel=0, counters cleared, FSMs go to RELEASED.
  - Synchronisers keep running.
  - After en returns to 1, a still-held button is re-debounced and yields a fresh press pulse.
- rst_n assert mid-hold or mid-debounce: immediate clear. After release of reset, behaviour is identical to a fresh en=1 start.
- oButton is never high for two consecutive cycles on the same bit. The parameter minimums guarantee this.

Decomposition:
- Shared package: button index constants (BTN_PREV=0, BTN_NEXT=1, BTN_OKAY=2, BTN_CANCEL=3), channel FSM state encoding (RELEASED, HELD, REPEATING), default timing constants.
- Sub-module: button_channel, holding one synchroniser, the debounce counter, the FSM and the repeat counter. The top instantiates it 4 times via generate, passing REPEAT_MASK[i].

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8, en=1 unless stated.)
1. Clean press: iButton[1] driven low at edge 0 and held -> oButton[1]=1 only at edge 6; oLevel[1]=1 from edge 6; no pulse on release.
2. Bounce: iButton[0] toggles every 2 cycles for 12 cycles, then held low -> exactly one oButton[0] pulse, 6 edges after the last transition.
3. Auto-repeat: Previous held, press pulse at P, raw released at P+50 -> pulses at P, P+20, P+28, P+36, P+44, P+52 (6 total); oLevel[0] falls at P+56; no further pulses.
4. No repeat on Okay: iButton[2] held 100 cycles -> exactly one oButton[2] pulse.
5. Simultaneous presses: iButton[0] and iButton[3] driven low on the same edge -> oButton=4'b1001 for one cycle at edge 6.
6. Enable drop: en dropped while Next is REPEATING -> oButton=0 and oLevel=0 on the next edge. en restored with the button still held -> new press pulse 4 edges after en rises (synchroniser already settled). Same check with an rst_n pulse instead of en.
